// File: rtl/jpeg_idct_pkg.sv
// rtl/jpeg_idct_pkg.sv - shared defaults and address/pointer helpers for the IDCT block buffer
// Purpose: default widths, transposed-read address mapping, bank pointer increment with wrap.
// Ports: none (package).
package jpeg_idct_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int BLK_ADDR_W_DEF = 6;

  // Helpers work on fixed maximum widths; callers cast to their own widths.
  localparam int ADDR_MAX_W = 16;
  localparam int PTR_MAX_W  = 8;

  // Swap the low and high halves of a w-bit block address: {a[h-1:0], a[w-1:h]}, h = w/2.
  // The caller must zero-extend a from w bits so the right shift brings in zeros.
  function automatic logic [ADDR_MAX_W-1:0] xpose_addr(input logic [ADDR_MAX_W-1:0] a,
                                                       input int w);
    int h;
    logic [ADDR_MAX_W-1:0] mask_lo;
    h       = w / 2;
    mask_lo = ADDR_MAX_W'((32'd1 << h) - 32'd1);
    return ((a & mask_lo) << (w - h)) | (a >> h);
  endfunction

  // Bank count need not be a power of two, so wrap is an explicit compare.
  function automatic logic [PTR_MAX_W-1:0] bank_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                    input int num_banks);
    if (32'(ptr) == 32'(num_banks - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/jpeg_idct_pingpong_buf_if.sv
// rtl/jpeg_idct_pingpong_buf_if.sv - writer/reader bus of the IDCT block buffer
// Purpose: groups flush, write side, read side and level signals.
// master: drives flush/write/read requests; slave: the buffer, drives ready/valid/data/level.
interface jpeg_idct_pingpong_buf_if #(
  parameter int DATA_W     = 16,
  parameter int BLK_ADDR_W = 6,
  parameter int NUM_BANKS  = 2
);
  localparam int LVL_W = $clog2(NUM_BANKS + 1);

  logic                  flush_i;
  logic                  wr_i;
  logic [BLK_ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0]     wr_data_i;
  logic                  wr_last_i;
  logic                  wr_ready_o;
  logic                  rd_i;
  logic [BLK_ADDR_W-1:0] rd_addr_i;
  logic                  rd_done_i;
  logic                  rd_valid_o;
  logic [DATA_W-1:0]     rd_data_o;
  logic                  rd_data_valid_o;
  logic [LVL_W-1:0]      level_o;

  modport master (
    output flush_i, wr_i, wr_addr_i, wr_data_i, wr_last_i, rd_i, rd_addr_i, rd_done_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, rd_data_valid_o, level_o
  );

  modport slave (
    input  flush_i, wr_i, wr_addr_i, wr_data_i, wr_last_i, rd_i, rd_addr_i, rd_done_i,
    output wr_ready_o, rd_valid_o, rd_data_o, rd_data_valid_o, level_o
  );

endinterface

// File: rtl/jpeg_idct_bank_ram.sv
// rtl/jpeg_idct_bank_ram.sv - 1W/1R synchronous RAM holding all blocks of the buffer
// Purpose: storage for NUM_BANKS blocks, read-first, registered read data.
// Ports: clk, rst_n (resets only the output register), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (holds when rd_en is low).
module jpeg_idct_bank_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of the old contents gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/jpeg_idct_pingpong_buf.sv
// rtl/jpeg_idct_pingpong_buf.sv - multi-bank block buffer between IDCT passes
// Purpose: writer fills/commits banks while reader drains earlier ones; optional transposed read.
// Ports: clk_i, rst_i (async, active-low), bus (slave modport): flush_i, wr_i/wr_addr_i/
//        wr_data_i/wr_last_i/wr_ready_o, rd_i/rd_addr_i/rd_done_i/rd_valid_o,
//        rd_data_o/rd_data_valid_o, level_o.
module jpeg_idct_pingpong_buf
  import jpeg_idct_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BLK_ADDR_W = BLK_ADDR_W_DEF,
  parameter int NUM_BANKS  = 2,
  parameter int TRANSPOSE  = 1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  jpeg_idct_pingpong_buf_if.slave bus
);

  localparam int PTR_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LVL_W  = $clog2(NUM_BANKS + 1);
  localparam int RAM_AW = PTR_W + BLK_ADDR_W;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(NUM_BANKS);

  logic [PTR_W-1:0]      wr_bank;
  logic [PTR_W-1:0]      rd_bank;
  logic [LVL_W-1:0]      count;
  logic                  wr_ready;
  logic                  rd_valid;
  logic                  wr_acc;
  logic                  commit;
  logic                  rd_acc;
  logic                  rel;
  logic                  rd_data_valid;
  logic [BLK_ADDR_W-1:0] rd_xaddr;

  // Ownership is derived purely from the committed-bank count.
  assign wr_ready = (count != FULL);
  assign rd_valid = (count != '0);

  assign wr_acc = bus.wr_i & wr_ready;
  assign commit = wr_acc & bus.wr_last_i;
  assign rd_acc = bus.rd_i & rd_valid;
  assign rel    = bus.rd_done_i & rd_valid;

  generate
    if (TRANSPOSE != 0) begin : g_xpose
      assign rd_xaddr = BLK_ADDR_W'(xpose_addr(ADDR_MAX_W'(bus.rd_addr_i), BLK_ADDR_W));
    end else begin : g_linear
      assign rd_xaddr = bus.rd_addr_i;
    end
  endgenerate

  // Flush overrides any commit/release arriving in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_bank <= '0;
      rd_bank <= '0;
      count   <= '0;
    end else if (bus.flush_i) begin
      wr_bank <= '0;
      rd_bank <= '0;
      count   <= '0;
    end else begin
      if (commit) begin
        wr_bank <= PTR_W'(bank_inc(PTR_MAX_W'(wr_bank), NUM_BANKS));
      end
      if (rel) begin
        rd_bank <= PTR_W'(bank_inc(PTR_MAX_W'(rd_bank), NUM_BANKS));
      end
      if (commit && !rel) begin
        count <= count + 1'b1;
      end else if (!commit && rel) begin
        count <= count - 1'b1;
      end
    end
  end

  // A read accepted during flush still completes, so the pulse ignores flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_acc;
    end
  end

  jpeg_idct_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (RAM_AW),
    .DEPTH  (NUM_BANKS << BLK_ADDR_W)
  ) u_ram (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .wr_en   (wr_acc & ~bus.flush_i),
    .wr_addr ({wr_bank, bus.wr_addr_i}),
    .wr_data (bus.wr_data_i),
    .rd_en   (rd_acc),
    .rd_addr ({rd_bank, rd_xaddr}),
    .rd_data (bus.rd_data_o)
  );

  assign bus.wr_ready_o      = wr_ready;
  assign bus.rd_valid_o      = rd_valid;
  assign bus.rd_data_valid_o = rd_data_valid;
  assign bus.level_o         = count;

endmodule

// File: tb/tb_jpeg_idct_pingpong_buf.sv
// tb/tb_jpeg_idct_pingpong_buf.sv - directed self-checking bench for jpeg_idct_pingpong_buf
module tb_jpeg_idct_pingpong_buf;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  jpeg_idct_pingpong_buf_if #(.DATA_W(16), .BLK_ADDR_W(6), .NUM_BANKS(2)) if2 ();
  jpeg_idct_pingpong_buf_if #(.DATA_W(16), .BLK_ADDR_W(6), .NUM_BANKS(3)) if3 ();

  jpeg_idct_pingpong_buf #(.DATA_W(16), .BLK_ADDR_W(6), .NUM_BANKS(2), .TRANSPOSE(1)) u_dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (if2)
  );

  jpeg_idct_pingpong_buf #(.DATA_W(16), .BLK_ADDR_W(6), .NUM_BANKS(3), .TRANSPOSE(1)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (if3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if2.flush_i = 0; if2.wr_i = 0; if2.wr_addr_i = '0; if2.wr_data_i = '0; if2.wr_last_i = 0;
    if2.rd_i = 0; if2.rd_addr_i = '0; if2.rd_done_i = 0;
    if3.flush_i = 0; if3.wr_i = 0; if3.wr_addr_i = '0; if3.wr_data_i = '0; if3.wr_last_i = 0;
    if3.rd_i = 0; if3.rd_addr_i = '0; if3.rd_done_i = 0;
  endtask

  task automatic wr2(input logic [5:0] a, input logic [15:0] d, input logic last);
    if2.wr_i = 1; if2.wr_addr_i = a; if2.wr_data_i = d; if2.wr_last_i = last;
    tick();
    if2.wr_i = 0; if2.wr_last_i = 0;
  endtask

  task automatic fill2(input logic [15:0] base, input int n, input logic do_commit);
    for (int i = 0; i < n; i++) begin
      wr2(6'(i), base + 16'(i), do_commit && (i == n - 1));
    end
  endtask

  task automatic rd2(input logic [5:0] a);
    if2.rd_i = 1; if2.rd_addr_i = a;
    tick();
    if2.rd_i = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    repeat (3) tick();
    check("rst_wr_ready", 32'(if2.wr_ready_o), 1);
    check("rst_rd_valid", 32'(if2.rd_valid_o), 0);
    check("rst_level", 32'(if2.level_o), 0);
    check("rst_rd_data", 32'(if2.rd_data_o), 0);
    check("rst_rd_dv", 32'(if2.rd_data_valid_o), 0);
    rst_n = 1'b1;
    tick();

    // bank 0: value = address
    fill2(16'h0000, 64, 1'b1);
    check("a_level", 32'(if2.level_o), 1);
    check("a_rd_valid", 32'(if2.rd_valid_o), 1);
    check("a_wr_ready", 32'(if2.wr_ready_o), 1);
    check("a_dv_idle", 32'(if2.rd_data_valid_o), 0);

    // transposed reads, back to back, then idle
    if2.rd_i = 1; if2.rd_addr_i = 6'd1;
    tick();
    check("t2_data_1", 32'(if2.rd_data_o), 8);
    check("t2_dv_1", 32'(if2.rd_data_valid_o), 1);
    if2.rd_addr_i = 6'd10;
    tick();
    check("t2_data_10", 32'(if2.rd_data_o), 17);
    check("t2_dv_10", 32'(if2.rd_data_valid_o), 1);
    if2.rd_i = 0;
    tick();
    check("t2_dv_off", 32'(if2.rd_data_valid_o), 0);
    check("t2_hold", 32'(if2.rd_data_o), 17);

    // fill bank 1 -> full; extra write with last is ignored
    fill2(16'h0100, 64, 1'b1);
    check("t3_level", 32'(if2.level_o), 2);
    check("t3_wr_ready", 32'(if2.wr_ready_o), 0);
    wr2(6'd5, 16'hBEEF, 1'b1);
    check("t3_level_after", 32'(if2.level_o), 2);
    rd2(6'd40);
    check("t3_bank0_intact", 32'(if2.rd_data_o), 5);

    // release bank 0, read bank 1
    if2.rd_done_i = 1;
    tick();
    if2.rd_done_i = 0;
    check("t4_level_rel", 32'(if2.level_o), 1);
    rd2(6'd0);
    check("t4_bank1_data", 32'(if2.rd_data_o), 16'h0100);

    // refill bank 0; commit and release in the same cycle
    fill2(16'h0200, 63, 1'b0);
    if2.wr_i = 1; if2.wr_addr_i = 6'd63; if2.wr_data_i = 16'h023F; if2.wr_last_i = 1;
    if2.rd_done_i = 1;
    tick();
    if2.wr_i = 0; if2.wr_last_i = 0; if2.rd_done_i = 0;
    check("t4_level_same", 32'(if2.level_o), 1);
    check("t4_wr_bank", 32'(u_dut2.wr_bank), 1);
    check("t4_rd_bank", 32'(u_dut2.rd_bank), 0);
    rd2(6'd1);
    check("t4_new_bank0", 32'(if2.rd_data_o), 16'h0208);

    // flush at level 2 with a concurrent read
    fill2(16'h0300, 64, 1'b1);
    check("t6_level_pre", 32'(if2.level_o), 2);
    if2.flush_i = 1; if2.rd_i = 1; if2.rd_addr_i = 6'd2; if2.rd_done_i = 1;
    tick();
    if2.flush_i = 0; if2.rd_i = 0; if2.rd_done_i = 0;
    check("t6_level", 32'(if2.level_o), 0);
    check("t6_rd_valid", 32'(if2.rd_valid_o), 0);
    check("t6_wr_ready", 32'(if2.wr_ready_o), 1);
    check("t6_dv", 32'(if2.rd_data_valid_o), 1);
    check("t6_data", 32'(if2.rd_data_o), 16'h0210);

    // flush discards an accepted write/commit in the same cycle
    wr2(6'd0, 16'h0777, 1'b1);
    check("t6b_level1", 32'(if2.level_o), 1);
    if2.flush_i = 1; if2.wr_i = 1; if2.wr_addr_i = 6'd16; if2.wr_data_i = 16'hDEAD;
    if2.wr_last_i = 1;
    tick();
    if2.flush_i = 0; if2.wr_i = 0; if2.wr_last_i = 0;
    check("t6b_level0", 32'(if2.level_o), 0);
    wr2(6'd0, 16'h0888, 1'b1);
    rd2(6'd2);
    check("t6b_no_write", 32'(if2.rd_data_o), 16'h0210);
    rd2(6'd0);
    check("t6b_new_word", 32'(if2.rd_data_o), 16'h0888);

    // async reset mid-fill
    fill2(16'h0400, 32, 1'b0);
    check("t1_level_pre", 32'(if2.level_o), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_wr_ready", 32'(if2.wr_ready_o), 1);
    check("t1_rd_valid", 32'(if2.rd_valid_o), 0);
    check("t1_level", 32'(if2.level_o), 0);
    check("t1_rd_data", 32'(if2.rd_data_o), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // three-bank wrap
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t5_wr_bank_%0d", i), 32'(u_dut3.wr_bank), 32'(i % 3));
      check($sformatf("t5_rd_bank_%0d", i), 32'(u_dut3.rd_bank), 32'(i % 3));
      if3.wr_i = 1; if3.wr_addr_i = 6'd0; if3.wr_data_i = 16'h0040 + 16'(i); if3.wr_last_i = 1;
      tick();
      if3.wr_i = 0; if3.wr_last_i = 0;
      check($sformatf("t5_level_%0d", i), 32'(if3.level_o), 1);
      if3.rd_i = 1; if3.rd_addr_i = 6'd0;
      tick();
      if3.rd_i = 0;
      check($sformatf("t5_data_%0d", i), 32'(if3.rd_data_o), 32'h40 + 32'(i));
      if3.rd_done_i = 1;
      tick();
      if3.rd_done_i = 0;
    end
    check("t5_level_end", 32'(if3.level_o), 0);
    check("t5_wr_bank_end", 32'(u_dut3.wr_bank), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
